change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Coin-payout end of the vending datapath. The coin-accept FSM counts nickels and dimes in; this block pays change out.
- Accepts a change request in nickel units and drives a dime/nickel ejector mechanism with a per-coin request/acknowledge handshake.
- Tracks on-board dime and nickel inventory and reports a shortfall when it cannot pay in full (empty tube or jammed ejector).

Parameters:
AMT_W, 4, width of amount/paid in nickel (5-cent) units; max request 15 = 75 cents
INV_W, 6, width of each coin inventory counter
DIME_INIT, 8, dime_cnt value after reset
NICKEL_INIT, 8, nickel_cnt value after reset
TIMEOUT, 16, cycles pay_* may stay high without coin_ack before it is declared a jam

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
amount  input  AMT_W  change owed in nickels; sampled with start
load  input  1  inventory reload; honoured only in IDLE
load_dimes  input  INV_W  new dime_cnt on load
load_nickels  input  INV_W  new nickel_cnt on load
coin_ack  input  1  ejector confirms one coin dropped
pay_dime  output  1  eject-one-dime request, level held until ack
pay_nickel  output  1  eject-one-nickel request, level held until ack
busy  output  1  high from cycle after accepted start through DONE
done  output  1  one-cycle completion pulse
short  output  1  last request not fully paid; valid from done until next accepted start
paid  output  AMT_W  nickels paid on current/last request
dime_cnt  output  INV_W  dimes in inventory
nickel_cnt  output  INV_W  nickels in inventory

Behaviour:
- All outputs registered.
- Reset (async, any state): state=IDLE; pay_dime=pay_nickel=busy=done=short=0; paid=0; remaining=0; timer=0; dime_cnt=DIME_INIT; nickel_cnt=NICKEL_INIT.
- States: IDLE, SELECT, WAIT_ACK, GAP, DONE.
- IDLE:
  - load=1: counts take load values.
  - start=1, amount>0: remaining=amount, paid=0, short=0, busy=1, go to SELECT.
  - start=1, amount=0: paid=0, short=0, busy=1, done=1, go to DONE.
  - start and load in the same cycle: both take effect; the new counts are used.
- SELECT (exactly 1 cycle), first matching rule wins:
  - remaining=0: go to DONE.
  - remaining>=2 and dime_cnt>0: pay_dime=1, timer=0, go to WAIT_ACK.
  - remaining>=1 and nickel_cnt>0: pay_nickel=1, timer=0, go to WAIT_ACK.
  - otherwise: short=1, go to DONE.
- WAIT_ACK:
  - Hold pay_* and increment timer.
  - coin_ack=1: drop pay_*; decrement the paid coin's count; remaining -= 2 (dime) or 1 (nickel); paid += same; go to GAP.
  - timer reaches TIMEOUT-1 without ack: drop pay_*, short=1, counts unchanged, go to DONE. pay_* is therefore high exactly TIMEOUT cycles.
- GAP: pay_* low; stay while coin_ack=1; go to SELECT on the first cycle coin_ack=0. This stops one held ack from being counted twice.
- DONE: done=1 for this single cycle, busy still 1; then go to IDLE with busy=0, done=0.
- Latency: with start sampled at edge 0, the first pay_* is high after edge 1. Ack at edge n puts GAP at n; coin_ack low at n+1 gives SELECT; next pay_* rises after n+2.
- Ignored inputs:
  - start while busy.
  - load outside IDLE.
  - coin_ack outside WAIT_ACK (except as the GAP stall condition).
- pay_dime and pay_nickel are never high together.
- Counters never underflow: SELECT checks for a nonzero count before requesting a coin.
- Arithmetic is unsigned; remaining never goes below 0 because a dime is chosen only when remaining>=2.

Test Plan:
1. After reset, start with amount=5; ack each coin 1 cycle after pay rises. Required: pay_dime, pay_dime, pay_nickel in that order; done one cycle; short=0; paid=5; dime_cnt=6; nickel_cnt=7; busy low the cycle after done.
2. start with amount=0. Required: done=1 in the cycle after start, no pay_* activity, paid=0, short=0, counts unchanged.
3. In IDLE, load with load_dimes=0, load_nickels=2; then start with amount=3. Required: two pay_nickel, then short=1 with done; paid=2; nickel_cnt=0; dime_cnt=0.
4. start with amount=2 and never assert coin_ack. Required: pay_dime high exactly 16 cycles, then low; short=1; done pulse; dime_cnt=8; paid=0.
5. Hold coin_ack high for 4 cycles on the first dime of amount=4. Required: only one coin counted, second pay_dime only after ack falls, paid=4. Pulse start mid-request: no effect.
6. Assert rst while pay_nickel is high in WAIT_ACK. Required: pay_nickel, busy, done, short, and paid all 0 immediately (asynchronously); counts at 8/8; state IDLE; a fresh start after rst release operates normally.

Source files
------------

// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
//
// Coin-payout side of the vending datapath. Takes a change request in nickel
// units and pays it out one coin at a time through a dime/nickel ejector using
// a level request (pay_dime / pay_nickel) and a single-cycle-or-longer
// acknowledge (coin_ack). Dimes are preferred while at least 10 cents remain.
// On-board inventory is tracked and a shortfall is flagged when the request
// cannot be paid in full, either because a tube is empty or because the
// ejector never acknowledged a coin (jam).
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   start, amount    request pulse and change owed (nickels), sampled in IDLE
//   load,
//   load_dimes,
//   load_nickels     inventory reload, honoured only in IDLE
//   coin_ack         ejector confirms one coin dropped
//   pay_dime,
//   pay_nickel       eject-one-coin requests, held until ack or timeout
//   busy             high from the cycle after an accepted start through DONE
//   done             one-cycle completion pulse
//   short            last request not fully paid (valid from done onward)
//   paid             nickels paid on the current/last request
//   dime_cnt,
//   nickel_cnt       coins currently in inventory
// -----------------------------------------------------------------------------
module change_dispenser #(
    parameter int AMT_W       = 4,
    parameter int INV_W       = 6,
    parameter int DIME_INIT   = 8,
    parameter int NICKEL_INIT = 8,
    parameter int TIMEOUT     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             load,
    input  logic [INV_W-1:0] load_dimes,
    input  logic [INV_W-1:0] load_nickels,
    input  logic             coin_ack,
    output logic             pay_dime,
    output logic             pay_nickel,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] paid,
    output logic [INV_W-1:0] dime_cnt,
    output logic [INV_W-1:0] nickel_cnt
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        WAIT_ACK,
        GAP,
        DONE
    } state_t;

    state_t           state,      state_nx;
    logic [AMT_W-1:0] remaining,  remaining_nx;
    logic [TMR_W-1:0] timer,      timer_nx;
    logic             pay_dime_nx, pay_nickel_nx, busy_nx, done_nx, short_nx;
    logic [AMT_W-1:0] paid_nx;
    logic [INV_W-1:0] dime_cnt_nx, nickel_cnt_nx;

    // State and every output live in this one register block, so all outputs
    // are registered and glitch-free toward the ejector.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            remaining  <= '0;
            timer      <= '0;
            pay_dime   <= 1'b0;
            pay_nickel <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            short      <= 1'b0;
            paid       <= '0;
            dime_cnt   <= INV_W'(DIME_INIT);
            nickel_cnt <= INV_W'(NICKEL_INIT);
        end else begin
            state      <= state_nx;
            remaining  <= remaining_nx;
            timer      <= timer_nx;
            pay_dime   <= pay_dime_nx;
            pay_nickel <= pay_nickel_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            short      <= short_nx;
            paid       <= paid_nx;
            dime_cnt   <= dime_cnt_nx;
            nickel_cnt <= nickel_cnt_nx;
        end
    end

    always_comb begin
        // NOTE: every signal gets a hold/default value before the case so no
        // path leaves it unassigned; otherwise a latch would be inferred.
        state_nx      = state;
        remaining_nx  = remaining;
        timer_nx      = timer;
        pay_dime_nx   = pay_dime;
        pay_nickel_nx = pay_nickel;
        busy_nx       = busy;
        done_nx       = 1'b0;
        short_nx      = short;
        paid_nx       = paid;
        dime_cnt_nx   = dime_cnt;
        nickel_cnt_nx = nickel_cnt;

        unique case (state)
            IDLE: begin
                // Reload and start may coincide; the reloaded counts are the
                // ones SELECT sees on the next cycle.
                if (load) begin
                    dime_cnt_nx   = load_dimes;
                    nickel_cnt_nx = load_nickels;
                end
                if (start) begin
                    paid_nx  = '0;
                    short_nx = 1'b0;
                    busy_nx  = 1'b1;
                    if (amount != '0) begin
                        remaining_nx = amount;
                        state_nx     = SELECT;
                    end else begin
                        done_nx  = 1'b1;
                        state_nx = DONE;
                    end
                end
            end

            SELECT: begin
                // Greedy: a dime only when at least two nickels are owed, so
                // remaining can never wrap below zero.
                if (remaining == '0) begin
                    done_nx  = 1'b1;
                    state_nx = DONE;
                end else if (remaining >= AMT_W'(2) && dime_cnt != '0) begin
                    pay_dime_nx = 1'b1;
                    timer_nx    = '0;
                    state_nx    = WAIT_ACK;
                end else if (nickel_cnt != '0) begin
                    pay_nickel_nx = 1'b1;
                    timer_nx      = '0;
                    state_nx      = WAIT_ACK;
                end else begin
                    short_nx = 1'b1;
                    done_nx  = 1'b1;
                    state_nx = DONE;
                end
            end

            WAIT_ACK: begin
                if (coin_ack) begin
                    pay_dime_nx   = 1'b0;
                    pay_nickel_nx = 1'b0;
                    if (pay_dime) begin
                        dime_cnt_nx  = dime_cnt - INV_W'(1);
                        remaining_nx = remaining - AMT_W'(2);
                        paid_nx      = paid + AMT_W'(2);
                    end else begin
                        nickel_cnt_nx = nickel_cnt - INV_W'(1);
                        remaining_nx  = remaining - AMT_W'(1);
                        paid_nx       = paid + AMT_W'(1);
                    end
                    state_nx = GAP;
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    // Jam: the request has been up for TIMEOUT cycles. The
                    // coin is not counted because it never confirmed.
                    pay_dime_nx   = 1'b0;
                    pay_nickel_nx = 1'b0;
                    short_nx      = 1'b1;
                    done_nx       = 1'b1;
                    state_nx      = DONE;
                end else begin
                    timer_nx = timer + TMR_W'(1);
                end
            end

            GAP: begin
                // Wait out a held ack so one long ack counts as one coin.
                if (!coin_ack) begin
                    state_nx = SELECT;
                end
            end

            DONE: begin
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end

            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser
//
// Directed steps followed by randomized requests. Expected coin sequences,
// paid totals, shortfall and inventory come from a greedy payout model that
// works on plain integers; the ejector side is emulated with a configurable
// ack delay, ack hold length and an optional jammed coin.
// -----------------------------------------------------------------------------
module tb_change_dispenser;

    localparam int AMT_W   = 4;
    localparam int INV_W   = 6;
    localparam int TIMEOUT = 16;
    localparam int BUDGET  = 400;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [AMT_W-1:0] amount;
    logic             load;
    logic [INV_W-1:0] load_dimes;
    logic [INV_W-1:0] load_nickels;
    logic             coin_ack;
    logic             pay_dime;
    logic             pay_nickel;
    logic             busy;
    logic             done;
    logic             short;
    logic [AMT_W-1:0] paid;
    logic [INV_W-1:0] dime_cnt;
    logic [INV_W-1:0] nickel_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // Reference inventory.
    int m_d = 8;
    int m_n = 8;

    change_dispenser #(
        .AMT_W      (AMT_W),
        .INV_W      (INV_W),
        .DIME_INIT  (8),
        .NICKEL_INIT(8),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .amount      (amount),
        .load        (load),
        .load_dimes  (load_dimes),
        .load_nickels(load_nickels),
        .coin_ack    (coin_ack),
        .pay_dime    (pay_dime),
        .pay_nickel  (pay_nickel),
        .busy        (busy),
        .done        (done),
        .short       (short),
        .paid        (paid),
        .dime_cnt    (dime_cnt),
        .nickel_cnt  (nickel_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic reload(input int d, input int n);
        load         = 1'b1;
        load_dimes   = INV_W'(d);
        load_nickels = INV_W'(n);
        tick();
        load = 1'b0;
        m_d  = d;
        m_n  = n;
        check("load dime_cnt", dime_cnt, d);
        check("load nickel_cnt", nickel_cnt, n);
    endtask

    // One full request. dly: cycles after pay rises before ack; hold: ack
    // length; jam_at: index of the coin never acked (-1 none); do_load: reload
    // in the start cycle; poke: pulse start/load mid-request (must be ignored).
    task automatic transact(input string name, input int amt, input int dly, input int hold,
                            input int jam_at, input bit do_load, input int ld_d, input int ld_n,
                            input bit poke);
        int exp_coins[$];
        int rem, e_paid, coin, cyc, n_coins, run_len, low_len, cd, hold_left;
        bit e_short, pend, pay_now, pay_prev, finished;

        // Reference: greedy payout in plain arithmetic.
        if (do_load) begin
            m_d = ld_d;
            m_n = ld_n;
        end
        rem = amt; e_paid = 0; e_short = 1'b0;
        while (rem > 0) begin
            if (rem >= 2 && m_d > 0) coin = 2;
            else if (m_n > 0)        coin = 1;
            else begin
                e_short = 1'b1;
                break;
            end
            exp_coins.push_back(coin);
            if (exp_coins.size() - 1 == jam_at) begin
                e_short = 1'b1;
                break;
            end
            rem    -= coin;
            e_paid += coin;
            if (coin == 2) m_d--;
            else           m_n--;
        end

        start        = 1'b1;
        amount       = AMT_W'(amt);
        load         = do_load;
        load_dimes   = INV_W'(ld_d);
        load_nickels = INV_W'(ld_n);
        tick();
        start = 1'b0;
        load  = 1'b0;

        cyc = 0; n_coins = 0; run_len = 0; low_len = 0; cd = 0; hold_left = 0;
        pend = 1'b0; pay_prev = 1'b0; finished = 1'b0;
        while (!finished) begin
            pay_now = pay_dime | pay_nickel;
            check({name, " exclusive pay"}, {31'b0, pay_dime & pay_nickel}, 0);
            check({name, " busy"}, busy, 1);
            if (pay_now && !pay_prev) begin
                if (n_coins == 0) check({name, " first pay latency"}, cyc, 1);
                else              check({name, " inter-coin gap"}, low_len, hold + 1);
                check({name, " coin type"}, pay_dime ? 2 : 1,
                      (n_coins < exp_coins.size()) ? exp_coins[n_coins] : 0);
                pend    = (n_coins != jam_at);
                cd      = dly;
                run_len = 0;
                low_len = 0;
                n_coins++;
            end
            if (pay_now) run_len++;
            else         low_len++;
            if (!pay_now && pay_prev)
                check({name, " pay high cycles"}, run_len,
                      (n_coins - 1 == jam_at) ? TIMEOUT : dly + 1);
            pay_prev = pay_now;

            if (done) begin
                check({name, " paid"}, paid, e_paid);
                check({name, " short"}, short, e_short);
                check({name, " dime_cnt"}, dime_cnt, m_d);
                check({name, " nickel_cnt"}, nickel_cnt, m_n);
                check({name, " coin count"}, n_coins, exp_coins.size());
                finished = 1'b1;
            end else if (cyc >= BUDGET) begin
                vectors++;
                miscompares++;
                $error("FAIL %s no done: observed none within %0d cycles, expected done", name, BUDGET);
                finished = 1'b1;
            end else begin
                if (hold_left > 0) begin
                    coin_ack = 1'b1;
                    hold_left--;
                end else if (pend && cd == 0) begin
                    coin_ack  = 1'b1;
                    hold_left = hold - 1;
                    pend      = 1'b0;
                end else begin
                    coin_ack = 1'b0;
                    if (pend) cd--;
                end
                if (poke && cyc == 2) begin
                    start        = 1'b1;
                    amount       = AMT_W'($urandom_range(1, 15));
                    load         = 1'b1;
                    load_dimes   = INV_W'($urandom_range(20, 40));
                    load_nickels = INV_W'($urandom_range(20, 40));
                end else begin
                    start = 1'b0;
                    load  = 1'b0;
                end
                tick();
                cyc++;
            end
        end
        coin_ack = 1'b0;
        start    = 1'b0;
        load     = 1'b0;
        tick();
        check({name, " done single cycle"}, done, 0);
        check({name, " busy low after done"}, busy, 0);
        check({name, " short held"}, short, e_short);
        check({name, " paid held"}, paid, e_paid);
    endtask

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; amount = '0; load = 1'b0;
        load_dimes = '0; load_nickels = '0; coin_ack = 1'b0;
        tick();
        check("reset pay_dime", pay_dime, 0);
        check("reset pay_nickel", pay_nickel, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset short", short, 0);
        check("reset paid", paid, 0);
        check("reset dime_cnt", dime_cnt, 8);
        check("reset nickel_cnt", nickel_cnt, 8);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // 1: 25 cents from full tubes -> dime, dime, nickel.
        transact("t1 amt5", 5, 1, 1, -1, 1'b0, 0, 0, 1'b0);
        // 2: zero request completes at once.
        transact("t2 amt0", 0, 0, 1, -1, 1'b0, 0, 0, 1'b0);
        // 3: no dimes, two nickels, 15 cents owed -> short.
        reload(0, 2);
        transact("t3 short", 3, 0, 1, -1, 1'b0, 0, 0, 1'b0);
        // 4: jammed ejector on a dime.
        reload(8, 8);
        transact("t4 jam", 2, 0, 1, 0, 1'b0, 0, 0, 1'b0);
        // 5: long ack counted once, start/load pokes ignored.
        transact("t5 held ack", 4, 0, 4, -1, 1'b0, 0, 0, 1'b1);
        // Load and start in the same cycle: new counts govern the payout.
        transact("load+start", 5, 2, 2, -1, 1'b1, 1, 9, 1'b0);

        for (int i = 0; i < 24; i++) begin
            int jam;
            jam = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
            transact("random", int'($urandom_range(0, 15)), int'($urandom_range(0, 5)),
                     int'($urandom_range(1, 4)), jam, ($urandom_range(0, 2) == 0),
                     int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
                     bit'($urandom_range(0, 1)));
        end

        // 6: asynchronous reset in the middle of a nickel request.
        reload(3, 5);
        start = 1'b1; amount = AMT_W'(1);
        tick();
        start = 1'b0;
        k = 0;
        while (!pay_nickel && k < 20) begin
            tick();
            k++;
        end
        check("t6 pay_nickel before rst", pay_nickel, 1);
        rst = 1'b1;
        #1;
        check("t6 async pay_nickel", pay_nickel, 0);
        check("t6 async busy", busy, 0);
        check("t6 async done", done, 0);
        check("t6 async short", short, 0);
        check("t6 async paid", paid, 0);
        check("t6 async dime_cnt", dime_cnt, 8);
        check("t6 async nickel_cnt", nickel_cnt, 8);
        @(negedge clk);
        rst = 1'b0;
        m_d = 8;
        m_n = 8;
        tick();
        check("t6 idle after rst", busy, 0);
        transact("t6 after rst", 3, 1, 1, -1, 1'b0, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
